// File: rtl/fetch_pkg.sv
// Shared state/cause encodings and default memory map for the fetch controller.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_RANGE    = 2'd1,
        CAUSE_MISALIGN = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } fault_cause_e;

    localparam logic [31:0] DEFAULT_RESET_PC       = 32'h0100_0000;
    localparam logic [31:0] DEFAULT_IMEM_BASE      = 32'h0100_0000;
    localparam int unsigned DEFAULT_IMEM_WORDS     = 512;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 15;

    // Address of the last fetchable word: base + 4*words - 4.
    function automatic logic [31:0] last_word_addr(input logic [31:0] base,
                                                   input logic [31:0] words);
        return base + {words[29:0], 2'b00} - 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bundle of the decode-side handshake, redirect and InstructionMemory port.
// The master modport is the fetch controller; slave is its environment.
interface instr_fetch_ctrl_if;
    import fetch_pkg::*;

    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_instr;
    logic [31:0]  out_pc;
    logic         fault;
    fault_cause_e fault_cause;
    logic [31:0]  fault_pc;
    logic         imem_fetch_enable;
    logic [31:0]  imem_read_address;
    logic         imem_fetched_instruction;
    logic [31:0]  imem_valid_instruction;

    modport master (
        input  redirect_valid, redirect_pc, out_ready,
               imem_fetched_instruction, imem_valid_instruction,
        output out_valid, out_instr, out_pc, fault, fault_cause, fault_pc,
               imem_fetch_enable, imem_read_address
    );

    modport slave (
        output redirect_valid, redirect_pc, out_ready,
               imem_fetched_instruction, imem_valid_instruction,
        input  out_valid, out_instr, out_pc, fault, fault_cause, fault_pc,
               imem_fetch_enable, imem_read_address
    );

endinterface

// File: rtl/fetch_addr_check.sv
// Combinational PC legality check: word alignment first, then memory window.
module fetch_addr_check
    import fetch_pkg::*;
(
    input  logic [31:0]  pc_i,
    input  logic [31:0]  base_i,
    input  logic [31:0]  words_i,
    output logic         ok_o,
    output fault_cause_e cause_o
);

    logic [31:0] last_addr;
    logic        misaligned;
    logic        out_of_range;

    assign last_addr    = last_word_addr(base_i, words_i);
    assign misaligned   = (pc_i[1:0] != 2'b00);
    assign out_of_range = (pc_i < base_i) || (pc_i > last_addr);
    assign ok_o         = !misaligned && !out_of_range;

    // Misalignment is reported even when the address is also out of range.
    assign cause_o = misaligned   ? CAUSE_MISALIGN :
                     out_of_range ? CAUSE_RANGE    : CAUSE_NONE;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one word fetch at a time,
// holds the returned word for decode, and handles redirects and faults.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter logic [31:0] IMEM_BASE      = DEFAULT_IMEM_BASE,
    parameter int unsigned IMEM_WORDS     = DEFAULT_IMEM_WORDS,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_ctrl_if.master bus
);

    localparam logic [3:0]  TIMEOUT_LIMIT = 4'(TIMEOUT_CYCLES);
    localparam logic [31:0] WORDS_VEC     = 32'(IMEM_WORDS);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  out_pc_q, out_pc_d;
    fault_cause_e cause_q, cause_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic         discard_q, discard_d;
    logic [3:0]   cnt_q, cnt_d;

    logic         addr_ok;
    fault_cause_e addr_cause;
    logic         fetch_en;
    logic [3:0]   cnt_inc;
    logic         timeout_hit;

    fetch_addr_check u_addr_check (
        .pc_i    (pc_q),
        .base_i  (IMEM_BASE),
        .words_i (WORDS_VEC),
        .ok_o    (addr_ok),
        .cause_o (addr_cause)
    );

    assign cnt_inc     = cnt_q + 4'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_LIMIT);

    // Next-state, PC, capture and fault bookkeeping for the fetch FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        out_pc_d   = out_pc_q;
        cause_d    = cause_q;
        fault_pc_d = fault_pc_q;
        discard_d  = discard_q;
        cnt_d      = cnt_q;
        fetch_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end

            ST_REQ: begin
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    state_d = ST_REQ;
                end else if (!addr_ok) begin
                    state_d    = ST_FAULT;
                    cause_d    = addr_cause;
                    fault_pc_d = pc_q;
                end else begin
                    fetch_en = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                    // A response or timeout landing with the redirect retires the
                    // in-flight fetch immediately; otherwise wait it out.
                    if (bus.imem_fetched_instruction || timeout_hit) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        discard_d = 1'b1;
                        cnt_d     = cnt_inc;
                    end
                end else if (bus.imem_fetched_instruction) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        instr_d  = bus.imem_valid_instruction;
                        out_pc_d = pc_q;
                        state_d  = ST_HOLD;
                    end
                end else if (timeout_hit) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        state_d    = ST_FAULT;
                        cause_d    = CAUSE_TIMEOUT;
                        fault_pc_d = pc_q;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_HOLD: begin
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    state_d = ST_REQ;
                end else if (bus.out_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_REQ;
                end
            end

            ST_FAULT: begin
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    cause_d = CAUSE_NONE;
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            out_pc_q   <= 32'd0;
            cause_q    <= CAUSE_NONE;
            fault_pc_q <= 32'd0;
            discard_q  <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            out_pc_q   <= out_pc_d;
            cause_q    <= cause_d;
            fault_pc_q <= fault_pc_d;
            discard_q  <= discard_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.out_valid         = (state_q == ST_HOLD);
    assign bus.out_instr         = instr_q;
    assign bus.out_pc            = out_pc_q;
    assign bus.fault             = (state_q == ST_FAULT);
    assign bus.fault_cause       = cause_q;
    assign bus.fault_pc          = fault_pc_q;
    assign bus.imem_fetch_enable = fetch_en;
    assign bus.imem_read_address = pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: a memory model with selectable latency,
// a stream model of expected (pc, word) deliveries and a decoupled monitor.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] LAST = 32'h0100_07FC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_ctrl_if fif ();

    instr_fetch_ctrl #(
        .RESET_PC       (BASE),
        .IMEM_BASE      (BASE),
        .IMEM_WORDS     (512),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
    endfunction

    // Reference model: after a reset or redirect to 'start', decode should see
    // consecutive words from 'start' up to the last legal address, in order.
    logic [31:0] exp_q[$];

    task automatic expect_stream(input logic [31:0] start);
        logic [31:0] a;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            a = start + 32'(4 * i);
            if (a[1:0] == 2'b00 && a >= BASE && a <= LAST) exp_q.push_back(a);
        end
    endtask

    // Environment controls.
    int mem_fix_lat = 1;   // 0: never respond, n: respond in the n-th cycle after the fetch
    bit mem_rand    = 1'b0;
    bit mem_junk    = 1'b0;
    int ready_mode  = 1;   // 0 low, 1 high, 2 random
    int phase       = 0;

    // Monitor state.
    int          cyc = -1;
    int          delivered = 0;
    bit          fe_seen = 1'b0;
    logic [31:0] addr_seen;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_pc, prev_instr;

    // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            cyc       = -1;
            prev_hold = 1'b0;
            fe_seen   = 1'b0;
        end else begin
            cyc++;
            fe_seen   = fif.imem_fetch_enable;
            addr_seen = fif.imem_read_address;
            if (phase == 1 && cyc >= 1 && cyc <= 12) begin
                check("fetch_cadence", 32'(fif.imem_fetch_enable), 32'(cyc % 3 == 1));
                check("valid_cadence", 32'(fif.out_valid), 32'(cyc % 3 == 0));
            end
            if (prev_hold && fif.out_valid) begin
                check("hold_pc_stable", fif.out_pc, prev_pc);
                check("hold_instr_stable", fif.out_instr, prev_instr);
            end
            if (fif.fault) check("no_fetch_in_fault", 32'(fif.imem_fetch_enable), 32'd0);
            if (fif.out_valid && fif.out_ready) begin
                check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("out_pc", fif.out_pc, e);
                    check("out_instr", fif.out_instr, word_of(e));
                end
                delivered++;
            end
            prev_hold  = fif.out_valid && !fif.out_ready && !fif.redirect_valid;
            prev_pc    = fif.out_pc;
            prev_instr = fif.out_instr;
        end
    end

    // Memory model: drives the response strobe/data 1 time unit after each edge.
    bit          mem_pending = 1'b0;
    int          mem_delay   = 0;
    int          mem_lat_now = 0;
    logic [31:0] mem_addr;

    always @(posedge clk) begin
        #1;
        fif.imem_fetched_instruction = 1'b0;
        fif.imem_valid_instruction   = $urandom;
        if (mem_pending) begin
            mem_delay--;
            if (mem_delay == 0) begin
                mem_pending = 1'b0;
                fif.imem_fetched_instruction = 1'b1;
                fif.imem_valid_instruction   = word_of(mem_addr);
            end
        end
        if (fe_seen) begin
            mem_lat_now = mem_rand ? int'($urandom_range(1, 4)) : mem_fix_lat;
            mem_addr    = addr_seen;
            if (mem_lat_now == 1) begin
                fif.imem_fetched_instruction = 1'b1;
                fif.imem_valid_instruction   = word_of(mem_addr);
            end else if (mem_lat_now > 1) begin
                mem_pending = 1'b1;
                mem_delay   = mem_lat_now - 1;
            end
        end
        if (mem_junk && !mem_pending && !fif.imem_fetched_instruction)
            fif.imem_fetched_instruction = 1'b1;
    end

    // Decode-side ready driver.
    always @(posedge clk) begin
        #2;
        fif.out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = t;
        step(1);
        fif.redirect_valid = 1'b0;
        fif.redirect_pc    = $urandom;
        expect_stream(t);
    endtask

    task automatic wait_delivered(input int n, input int budget, input string name);
        int tgt;
        int k;
        tgt = delivered + n;
        k   = 0;
        while (delivered < tgt && k < budget) begin
            step(1);
            k++;
        end
        check(name, 32'(delivered >= tgt), 32'd1);
    endtask

    task automatic wait_fault(input int budget, input string name);
        int k;
        k = 0;
        while (!fif.fault && k < budget) begin
            step(1);
            k++;
        end
        check(name, 32'(fif.fault), 32'd1);
    endtask

    task automatic wait_fetch(input int budget, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!fif.imem_fetch_enable && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(fif.imem_fetch_enable), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(fif.out_valid), 32'd0);
        check({tag, "_out_instr"}, fif.out_instr, 32'd0);
        check({tag, "_out_pc"}, fif.out_pc, 32'd0);
        check({tag, "_fault"}, 32'(fif.fault), 32'd0);
        check({tag, "_fault_cause"}, 32'(fif.fault_cause), 32'd0);
        check({tag, "_fault_pc"}, fif.fault_pc, 32'd0);
        check({tag, "_fetch_enable"}, 32'(fif.imem_fetch_enable), 32'd0);
        check({tag, "_read_address"}, fif.imem_read_address, BASE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        fif.redirect_valid = 1'b0;
        fif.redirect_pc    = 32'd0;

        // Reset, then nominal 1-cycle memory with decode always ready.
        rst_n = 1'b0;
        step(3);
        expect_stream(BASE);
        phase = 1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        wait_delivered(4, 20, "nominal_stream");
        phase = 0;

        // Decode stalls in HOLD for 5 cycles while junk strobes arrive.
        mem_rand   = 1'b1;
        ready_mode = 0;
        k = 0;
        while (!(fif.out_valid && !fif.out_ready) && k < 30) begin
            step(1);
            k++;
        end
        check("stall_reached", 32'(fif.out_valid && !fif.out_ready), 32'd1);
        mem_junk = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("no_fetch_in_hold", 32'(fif.imem_fetch_enable), 32'd0);
            check("valid_held", 32'(fif.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        mem_junk   = 1'b0;
        ready_mode = 1;
        wait_delivered(3, 60, "resume_after_stall");

        // Run off the end of memory with random ready and latency.
        ready_mode = 2;
        redirect_to(32'h0100_07F0);
        wait_fault(200, "range_fault_seen");
        check("range_cause", 32'(fif.fault_cause), 32'd1);
        check("range_fault_pc", fif.fault_pc, 32'h0100_0800);
        check("range_read_address", fif.imem_read_address, 32'h0100_0800);
        check("last_words_delivered", 32'(exp_q.size()), 32'd0);
        step(3);
        redirect_to(BASE);
        check("fault_cleared", 32'(fif.fault), 32'd0);
        check("cause_cleared", 32'(fif.fault_cause), 32'd0);
        wait_delivered(3, 100, "resume_after_range");

        // Misaligned redirect target.
        redirect_to(32'h0100_0002);
        wait_fault(10, "misalign_fault_seen");
        check("misalign_cause", 32'(fif.fault_cause), 32'd2);
        check("misalign_fault_pc", fif.fault_pc, 32'h0100_0002);

        // Redirect while a slow response is in flight: that word must be dropped.
        mem_rand    = 1'b0;
        mem_fix_lat = 4;
        redirect_to(BASE);
        wait_fetch(10, "slow_fetch_issued");
        @(posedge clk);
        #1;
        mem_fix_lat = 1;
        redirect_to(32'h0100_0100);
        wait_delivered(2, 60, "after_wait_redirect");

        // Redirect while the in-flight fetch never returns: timeout is silent.
        mem_fix_lat = 0;
        redirect_to(32'h0100_0200);
        wait_fetch(10, "silent_fetch_issued");
        @(posedge clk);
        #1;
        mem_fix_lat = 1;
        redirect_to(32'h0100_0300);
        wait_delivered(2, 80, "discard_timeout_recovers");
        check("no_fault_after_discard", 32'(fif.fault), 32'd0);

        // Memory never responds: timeout fault after 15 WAIT cycles.
        mem_fix_lat = 0;
        redirect_to(32'h0100_0010);
        wait_fetch(10, "timeout_fetch_issued");
        k = 0;
        while (!fif.fault && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("timeout_wait_cycles", 32'(k - 1), 32'd15);
        check("timeout_cause", 32'(fif.fault_cause), 32'd3);
        check("timeout_fault_pc", fif.fault_pc, 32'h0100_0010);
        @(posedge clk);
        #1;

        // One-cycle reset while a word is held.
        mem_fix_lat = 1;
        ready_mode  = 0;
        redirect_to(32'h0100_0040);
        k = 0;
        while (!(fif.out_valid && !fif.out_ready) && k < 30) begin
            step(1);
            k++;
        end
        check("hold_before_reset", 32'(fif.out_valid), 32'd1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_reset_outputs("midrun_reset");
        expect_stream(BASE);
        ready_mode = 1;
        wait_delivered(2, 40, "restart_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
